ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
Scan sequencer that time-shares one sigma-delta ADC core across NUM_CH comparator inputs behind an external analog mux.
- Per channel: selects the channel, holds the ADC core in reset while the RC network settles, discards stale averaged samples, then captures one result.
- Presents each result on a valid/ready interface and repeats scans continuously while enabled.
- Sits between the ADC core (its sample_rdy/digital_out) and the register/host side.

Parameters:
NUM_CH, 4, number of multiplexed analog channels (2..16)
CH_BITS, 2, width of channel index; equals clog2(NUM_CH)
ADC_WIDTH, 8, ADC result width
SETTLE_CYCLES, 16, clk cycles adc_rstn is held low after a mux change (>=1)
DISCARD_SAMPLES, 1, sample_rdy pulses ignored before capture (0..15)

Ports:
clk  in  1  system/sample clock
rstn  in  1  synchronous reset, active low
enable  in  1  level; 1 = run continuous scans
chan_mask  in  NUM_CH  per-channel enable; latched at scan start
adc_sample_rdy  in  1  one-cycle pulse from ADC core: adc_digital_out valid
adc_digital_out  in  ADC_WIDTH  averaged ADC word
adc_rstn  out  1  active-low reset to ADC core (drives its rstn)
mux_sel  out  CH_BITS  analog mux channel select
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_chan  out  CH_BITS  channel of result
result_data  out  ADC_WIDTH  captured ADC word
busy  out  1  1 whenever state != IDLE
scan_done  out  1  one-cycle pulse when the last enabled channel's result is accepted

Behaviour:
- All state updates on posedge clk. rstn=0 sampled at an edge forces the following values; takes priority over every other event, including mid-handshake:
  - state=IDLE, mux_sel=0, adc_rstn=0
  - result_valid=0, result_chan=0, result_data=0
  - busy=0, scan_done=0
  - counters=0, latched mask=0
- States: IDLE, SETTLE, DISCARD, CAPTURE, OUTPUT.
- IDLE:
  - adc_rstn=0.
  - If enable=1 and chan_mask!=0: latch mask; set mux_sel to the lowest set bit; go to SETTLE with settle counter cleared.
  - If chan_mask==0: stay IDLE.
- SETTLE:
  - adc_rstn=0; counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE: adc_rstn=1 and go to DISCARD, or to CAPTURE if DISCARD_SAMPLES=0.
- DISCARD:
  - Each cycle with adc_sample_rdy=1 increments the discard count.
  - When the count reaches DISCARD_SAMPLES: go to CAPTURE.
- CAPTURE:
  - On the first adc_sample_rdy=1 while in CAPTURE: result_data<=adc_digital_out, result_chan<=mux_sel, result_valid<=1, go to OUTPUT.
  - A pulse coincident with the edge entering CAPTURE belongs to DISCARD (already counted), never to CAPTURE.
- OUTPUT:
  - result_valid stays 1; result_data and result_chan stay stable until result_ready=1 is sampled with valid=1.
  - On acceptance: result_valid<=0.
  - Next channel = next set bit of the latched mask above mux_sel, without wrap.
    - Exists: mux_sel<=next, go to SETTLE.
    - None: scan_done<=1 for one cycle; if enable=1, relatch chan_mask and restart at its lowest set bit (SETTLE); else go to IDLE.
  - adc_rstn drops to 0 on the same edge that leaves OUTPUT.
- Single-channel mask: mux_sel is unchanged between scans, but the full SETTLE/DISCARD sequence still runs.
- enable=0:
  - In SETTLE/DISCARD/CAPTURE: abort to IDLE on the next edge; no result is produced; scan_done is not pulsed.
  - In OUTPUT: the pending handshake completes, then the block goes to IDLE.
- chan_mask changes mid-scan are ignored until the next scan start.
- Latency per channel: SETTLE_CYCLES + 1 + (DISCARD_SAMPLES+1) ADC sample periods + handshake wait.
- Counter widths:
  - Settle counter: clog2(SETTLE_CYCLES+1).
  - Discard counter: 4 bits.
  - No wrap is possible within legal parameter ranges.

Decomposition:
- Package ssd_pkg holds:
  - State encoding (5 states, binary).
  - Default ADC_WIDTH.
  - A function for next-set-bit-above-index over an NUM_CH mask.
- One sub-module, ssd_chan_pick: combinational priority picker.
  - Inputs: mask, current index, start flag.
  - Outputs: next index, found flag.

Test Plan:
- Reset/idle: enable=1, chan_mask=0, then rstn=0 asserted for 1 cycle mid-CAPTURE on a 4'b0001 run → after reset all outputs equal their reset values; with mask 0, busy stays 0.
- Full scan: mask=4'b1011, ADC model returns 8'h10+ch on every sample_rdy, ready tied 1 → results (0,0x10),(1,0x11),(3,0x13) in order; scan_done pulse after ch3; ch2 never selected.
- Settle/discard timing: mask=4'b0100, SETTLE_CYCLES=16, DISCARD_SAMPLES=1 → adc_rstn low exactly 16 cycles after mux_sel=2; first sample_rdy discarded; second sample captured.
- Backpressure: hold result_ready=0 for 50 cycles while sample_rdy keeps pulsing → result_valid, data and chan stable; mux_sel unchanged; later pulses do not overwrite the result.
- Abort: deassert enable in DISCARD → IDLE next cycle, adc_rstn=0, no result_valid, no scan_done. Deassert enable in OUTPUT → handshake completes, then IDLE.
- Mask change mid-scan: start with 4'b0011, switch to 4'b1100 during ch0 → ch1 is scanned; the next scan starts at ch2.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and helpers for the sigma-delta scan sequencer.
//               Holds the scan FSM state encoding, the default ADC word width
//               and a next-set-bit search used by the channel picker.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  localparam int ADC_WIDTH_DEFAULT = 8;

  // Widest channel mask the picker helper handles.
  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_DISCARD = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  // Index of the lowest set bit of mask strictly above idx, or the lowest
  // set bit overall when start is 1. Returns -1 when no such bit exists.
  function automatic int next_set_bit(input logic [MAX_CH-1:0] mask,
                                      input int                idx,
                                      input logic              start);
    int pick;
    pick = -1;
    // Walk downwards so the lowest qualifying bit is the last one written.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (start || (i > idx))) begin
        pick = i;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_chan_pick.sv
`default_nettype none
// ============================================================================
// Module      : ssd_chan_pick
// Description : Combinational priority picker over a channel mask.
//               mask     - per-channel enable bits
//               idx      - current channel index
//               start    - 1: return lowest set bit; 0: lowest set bit > idx
//               next_idx - selected channel (0 when none found)
//               found    - a qualifying channel exists
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_chan_pick
  import ssd_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic [NUM_CH-1:0]  mask,
  input  logic [CH_BITS-1:0] idx,
  input  logic               start,
  output logic [CH_BITS-1:0] next_idx,
  output logic               found
);

  int pick;

  always_comb begin
    pick     = next_set_bit(MAX_CH'(mask), int'(idx), start);
    found    = (pick >= 0);
    next_idx = found ? CH_BITS'(pick) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Scan sequencer sharing one sigma-delta ADC core across NUM_CH
//               analog-mux inputs. Per channel: select, hold the ADC in reset
//               while the RC network settles, drop stale averaged samples,
//               capture one word and hand it out on a valid/ready port.
// Ports       : clk, rstn (sync, active low), enable, chan_mask
//               adc_sample_rdy/adc_digital_out  <- ADC core
//               adc_rstn/mux_sel                -> ADC core / analog mux
//               result_valid/ready/chan/data    <-> host side
//               busy, scan_done                 -> status
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int CH_BITS         = 2,
  parameter int ADC_WIDTH       = ADC_WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DISCARD_SAMPLES = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    chan_mask,
  input  logic                 adc_sample_rdy,
  input  logic [ADC_WIDTH-1:0] adc_digital_out,
  output logic                 adc_rstn,
  output logic [CH_BITS-1:0]   mux_sel,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CH_BITS-1:0]   result_chan,
  output logic [ADC_WIDTH-1:0] result_data,
  output logic                 busy,
  output logic                 scan_done
);

  localparam int                  SETTLE_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]          DISCARD_LAST = 4'(DISCARD_SAMPLES - 1);

  state_t                 state, state_n;
  logic [NUM_CH-1:0]      mask_q, mask_n;
  logic [CH_BITS-1:0]     mux_n, chan_n;
  logic [SETTLE_W-1:0]    settle_cnt, settle_n;
  logic [3:0]             disc_cnt, disc_n;
  logic                   valid_n, done_n, adc_rstn_n;
  logic [ADC_WIDTH-1:0]   data_n;

  logic [CH_BITS-1:0]     next_idx, first_idx;
  logic                   next_found, first_found;

  // Next channel of the running scan (latched mask, strictly above mux_sel).
  ssd_chan_pick #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_pick_next (
    .mask     (mask_q),
    .idx      (mux_sel),
    .start    (1'b0),
    .next_idx (next_idx),
    .found    (next_found)
  );

  // First channel of a new scan, taken from the live mask.
  ssd_chan_pick #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_pick_first (
    .mask     (chan_mask),
    .idx      ('0),
    .start    (1'b1),
    .next_idx (first_idx),
    .found    (first_found)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    mux_n    = mux_sel;
    settle_n = settle_cnt;
    disc_n   = disc_cnt;
    valid_n  = result_valid;
    chan_n   = result_chan;
    data_n   = result_data;
    done_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable && first_found) begin
          mask_n   = chan_mask;
          mux_n    = first_idx;
          settle_n = '0;
          state_n  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          disc_n  = '0;
          state_n = (DISCARD_SAMPLES == 0) ? ST_CAPTURE : ST_DISCARD;
        end else begin
          settle_n = settle_cnt + SETTLE_W'(1);
        end
      end

      ST_DISCARD: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (adc_sample_rdy) begin
          // The pulse that completes the discard count is consumed here, so
          // CAPTURE only ever sees strictly later samples.
          disc_n = disc_cnt + 4'd1;
          if (disc_cnt == DISCARD_LAST) begin
            state_n = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (adc_sample_rdy) begin
          data_n  = adc_digital_out;
          chan_n  = mux_sel;
          valid_n = 1'b1;
          state_n = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        if (result_ready) begin
          valid_n = 1'b0;
          if (!enable) begin
            // Handshake finished; stop here. Only a completed scan reports.
            done_n  = !next_found;
            state_n = ST_IDLE;
          end else if (next_found) begin
            mux_n    = next_idx;
            settle_n = '0;
            state_n  = ST_SETTLE;
          end else begin
            done_n = 1'b1;
            if (first_found) begin
              mask_n   = chan_mask;
              mux_n    = first_idx;
              settle_n = '0;
              state_n  = ST_SETTLE;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // ADC runs only once the mux input has settled; registered so the core
    // reset pin sees a clean level.
    adc_rstn_n = (state_n == ST_DISCARD) || (state_n == ST_CAPTURE) ||
                 (state_n == ST_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      mux_sel      <= '0;
      settle_cnt   <= '0;
      disc_cnt     <= '0;
      adc_rstn     <= 1'b0;
      result_valid <= 1'b0;
      result_chan  <= '0;
      result_data  <= '0;
      scan_done    <= 1'b0;
    end else begin
      state        <= state_n;
      mask_q       <= mask_n;
      mux_sel      <= mux_n;
      settle_cnt   <= settle_n;
      disc_cnt     <= disc_n;
      adc_rstn     <= adc_rstn_n;
      result_valid <= valid_n;
      result_chan  <= chan_n;
      result_data  <= data_n;
      scan_done    <= done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Self-checking bench for ssd_scan_ctrl. An emulated ADC core
//               issues sample_rdy pulses at random spacing while adc_rstn is
//               high; the expected capture of each channel visit is the
//               (DISCARD+1)-th pulse of that visit, and the expected channel
//               order comes from the set bits of the scan mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

  localparam int NUM_CH  = 4;
  localparam int CH_BITS = 2;
  localparam int ADC_W   = 8;
  localparam int SETTLE  = 16;
  localparam int DISCARD = 1;

  logic              clk = 1'b0;
  logic              rstn, enable;
  logic [NUM_CH-1:0] chan_mask;
  logic              adc_sample_rdy;
  logic [ADC_W-1:0]  adc_digital_out;
  logic              adc_rstn;
  logic [CH_BITS-1:0] mux_sel;
  logic              result_valid, result_ready;
  logic [CH_BITS-1:0] result_chan;
  logic [ADC_W-1:0]  result_data;
  logic              busy, scan_done;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .ADC_WIDTH(ADC_W),
    .SETTLE_CYCLES(SETTLE), .DISCARD_SAMPLES(DISCARD)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .chan_mask(chan_mask),
    .adc_sample_rdy(adc_sample_rdy), .adc_digital_out(adc_digital_out),
    .adc_rstn(adc_rstn), .mux_sel(mux_sel),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_chan(result_chan), .result_data(result_data),
    .busy(busy), .scan_done(scan_done)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // ADC emulation and reference model state
  int   adc_timer = 0, adc_period = 3, fixed_period = 0, visit_pulses = 0;
  bit   pattern_mode = 1'b0, saw_ch2 = 1'b0;
  logic [9:0] exp_q[$];       // {chan, data} expected per channel visit
  int   exp_chan_q[$];        // expected channel order
  bit   exp_last_q[$];        // 1 when that channel ends its scan

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: advance, then act as the ADC core for the coming edge.
  task automatic tick();
    @(posedge clk); #1;
    if (busy === 1'b1 && mux_sel === 2'd2) saw_ch2 = 1'b1;
    if (adc_rstn !== 1'b1) begin
      adc_timer      = 0;
      visit_pulses   = 0;
      adc_sample_rdy = 1'b0;
    end else begin
      adc_timer++;
      if (adc_timer >= adc_period) begin
        adc_timer       = 0;
        adc_period      = (fixed_period != 0) ? fixed_period : int'($urandom_range(2, 5));
        adc_sample_rdy  = 1'b1;
        adc_digital_out = pattern_mode ? (8'h10 + {6'd0, mux_sel}) : 8'($urandom);
        visit_pulses++;
        if (visit_pulses == DISCARD + 1) exp_q.push_back({mux_sel, adc_digital_out});
      end else begin
        adc_sample_rdy = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_chan_q.delete();
    exp_last_q.delete();
  endtask

  task automatic plan_scan(input logic [NUM_CH-1:0] m);
    int last;
    last = -1;
    for (int c = 0; c < NUM_CH; c++) if (m[c]) last = c;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) begin
        exp_chan_q.push_back(c);
        exp_last_q.push_back(c == last);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_adc_rstn"},  adc_rstn, 0);
    chk({tag, "_mux_sel"},   mux_sel, 0);
    chk({tag, "_valid"},     result_valid, 0);
    chk({tag, "_chan"},      result_chan, 0);
    chk({tag, "_data"},      result_data, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
  endtask

  // Accept n results, checking each against the model and scan_done after it.
  task automatic collect(input string tag, input int n, input bit rand_ready);
    int         got, guard;
    bit         last;
    logic [9:0] e;
    got = 0; guard = 0;
    while (got < n && guard < 4000) begin
      result_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (result_valid === 1'b1 && result_ready) begin
        chk({tag, "_chan_order"}, result_chan, exp_chan_q[0]);
        chk({tag, "_model_entry"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_chan"}, result_chan, e[9:8]);
          chk({tag, "_data"}, result_data, e[7:0]);
        end
        last = exp_last_q.pop_front();
        void'(exp_chan_q.pop_front());
        tick();
        chk({tag, "_scan_done"}, scan_done, last);
        chk({tag, "_valid_clr"}, result_valid, 0);
        got++;
      end else begin
        tick();
      end
      guard++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    int         n;
    bit         flag;
    logic [1:0] hold_chan;
    logic [7:0] hold_data;
    logic [9:0] e;
    logic [NUM_CH-1:0] m;

    rstn = 1'b0; enable = 1'b0; chan_mask = '0; result_ready = 1'b0;
    adc_sample_rdy = 1'b0; adc_digital_out = '0;

    // ---- reset state
    repeat (3) tick();
    chk_reset("por");
    rstn = 1'b1;

    // ---- enabled with empty mask: never leaves IDLE
    enable = 1'b1; chan_mask = 4'b0000; flag = 1'b0;
    repeat (10) begin tick(); flag |= busy; end
    chk("mask0_busy", flag, 0);

    // ---- reset pulse while in CAPTURE
    chan_mask = 4'b0001; fixed_period = 6; n = 0;
    while (visit_pulses != DISCARD && n < 200) begin tick(); n++; end
    chk("rc_reach_discard", visit_pulses, DISCARD);
    tick();                      // discard pulse consumed: now in CAPTURE
    rstn = 1'b0;
    tick();
    chk_reset("mid_capture");
    rstn = 1'b1; enable = 1'b0; chan_mask = '0;
    tick();
    clear_model();

    // ---- full scan 1011, ADC returns 0x10+ch, ready tied high
    fixed_period = 0; pattern_mode = 1'b1; saw_ch2 = 1'b0;
    chan_mask = 4'b1011; enable = 1'b1;
    plan_scan(4'b1011);
    collect("full", 3, 1'b0);
    enable = 1'b0;
    repeat (2) tick();
    chk("full_no_ch2", saw_ch2, 0);
    chk("full_idle", busy, 0);
    pattern_mode = 1'b0;
    clear_model();

    // ---- settle length and discard of the first sample
    fixed_period = 4; chan_mask = 4'b0100; enable = 1'b1;
    plan_scan(4'b0100);
    tick();
    chk("settle_mux", mux_sel, 2);
    chk("settle_adc_low", adc_rstn, 0);
    n = 0;
    while (adc_rstn !== 1'b1 && n < 100) begin tick(); n++; end
    chk("settle_len", n, SETTLE);
    collect("discard", 1, 1'b0);
    enable = 1'b0;
    repeat (2) tick();
    clear_model();

    // ---- backpressure, then enable dropped while in OUTPUT
    fixed_period = 0; chan_mask = 4'b0010; enable = 1'b1; result_ready = 1'b0;
    n = 0;
    while (result_valid !== 1'b1 && n < 400) begin tick(); n++; end
    chk("bp_valid", result_valid, 1);
    chk("bp_model_entry", exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
    chk("bp_chan", result_chan, 1);
    chk("bp_data", result_data, e[7:0]);
    hold_chan = result_chan; hold_data = result_data; flag = 1'b1;
    repeat (50) begin
      tick();
      if (result_valid !== 1'b1 || result_chan !== hold_chan ||
          result_data !== hold_data || mux_sel !== 2'd1) flag = 1'b0;
    end
    chk("bp_stable", flag, 1);
    enable = 1'b0; result_ready = 1'b1;
    tick();
    chk("outabort_valid", result_valid, 0);
    chk("outabort_done", scan_done, 1);
    chk("outabort_idle", busy, 0);
    chk("outabort_adc", adc_rstn, 0);
    tick();
    clear_model();

    // ---- enable dropped in DISCARD
    fixed_period = 8; chan_mask = 4'b0001; enable = 1'b1;
    n = 0;
    while (adc_rstn !== 1'b1 && n < 100) begin tick(); n++; end
    chk("abort_in_discard", adc_rstn, 1);
    enable = 1'b0;
    tick();
    chk("abort_idle", busy, 0);
    chk("abort_adc", adc_rstn, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_done", scan_done, 0);
    flag = 1'b0;
    repeat (20) begin tick(); flag |= result_valid | scan_done; end
    chk("abort_quiet", flag, 0);
    clear_model();

    // ---- mask change mid-scan
    fixed_period = 0; chan_mask = 4'b0011; enable = 1'b1; result_ready = 1'b1;
    tick();
    chk("mchg_start_mux", mux_sel, 0);
    chk("mchg_start_busy", busy, 1);
    chan_mask = 4'b1100;
    plan_scan(4'b0011);
    plan_scan(4'b1100);
    collect("mchg", 4, 1'b0);
    enable = 1'b0;
    repeat (2) tick();
    clear_model();

    // ---- random masks, two scans each, random backpressure
    for (int it = 0; it < 3; it++) begin
      m = 4'($urandom_range(1, 15));
      chan_mask = m; enable = 1'b1;
      plan_scan(m);
      plan_scan(m);
      collect("rand", 2 * $countones(m), 1'b1);
      enable = 1'b0;
      repeat (2) tick();
      chk("rand_idle", busy, 0);
      clear_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
